// File: rtl/mult_control_pkg.sv
// Shared types for the shift-add multiplier sequencer.
package mult_pkg;

  typedef enum logic [2:0] {IDLE, START, ADD, SHIFT, HOLD} mult_state_t;

  localparam int MULT_ITER = 8;

endpackage

// File: rtl/mult_control_if.sv
// Control bundle between the multiplier sequencer and its datapath.
interface mult_control_if;

  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Ld_B;
  logic Clr_A;
  logic Add;
  logic Sub;
  logic Shift_En;
  logic Busy;
  logic Done;

  // master is the datapath/request side, slave is the sequencer
  modport master (
    output Run, ClearA_LoadB, M,
    input  Ld_B, Clr_A, Add, Sub, Shift_En, Busy, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output Ld_B, Clr_A, Add, Sub, Shift_En, Busy, Done
  );

endinterface

// File: rtl/mult_control.sv
// Sequencer for the 8-bit signed shift-add multiplier: one multiply per Run, Done 17 cycles after Run.
// No backpressure; Done is held until Run drops, and Reset forces every output low.
module mult_control
  import mult_pkg::*;
#(
  parameter int ITER = MULT_ITER
) (
  input  logic           Clk,
  input  logic           Reset,
  mult_control_if.slave  bus
);

  localparam int              CW   = $clog2(ITER);
  localparam logic [CW-1:0]   LAST = CW'(ITER - 1);

  mult_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last;

  logic ld_b, clr_a, add, sub, shift_en, busy, done;

  assign last = (cnt == LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_b      = 1'b0;
    clr_a     = 1'b0;
    add       = 1'b0;
    sub       = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state)
      IDLE: begin
        // Run takes priority over a concurrent load request
        if (bus.Run) begin
          state_nxt = START;
        end else if (bus.ClearA_LoadB) begin
          ld_b  = 1'b1;
          clr_a = 1'b1;
        end
      end
      START: begin
        clr_a     = 1'b1;
        busy      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ADD;
      end
      ADD: begin
        busy      = 1'b1;
        add       = bus.M;
        // final iteration subtracts for the multiplier's sign weight
        sub       = bus.M & last;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (last) begin
          state_nxt = HOLD;
        end else begin
          cnt_nxt   = cnt + CW'(1);
          state_nxt = ADD;
        end
      end
      HOLD: begin
        done = 1'b1;
        if (!bus.Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (Reset) begin
      ld_b     = 1'b0;
      clr_a    = 1'b0;
      add      = 1'b0;
      sub      = 1'b0;
      shift_en = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
    end
  end

  assign bus.Ld_B     = ld_b;
  assign bus.Clr_A    = clr_a;
  assign bus.Add      = add;
  assign bus.Sub      = sub;
  assign bus.Shift_En = shift_en;
  assign bus.Busy     = busy;
  assign bus.Done     = done;

endmodule

// File: doc/mult_control.md
# mult_control

Sequencing FSM for the 8-bit signed shift-add multiplier. It sits directly upstream of the A and B 8-bit shift registers, the X sign flip-flop and the 9-bit add/subtract unit, and drives their load, clear and shift controls. It examines the current multiplier LSB M (B register bit 0) each iteration. It runs 8 add/shift iterations per Run request, subtracting on the eighth iteration for two's-complement correction.

## Interface
Parameters:
- ITER, 8: number of add/shift iterations; counter width is $clog2(ITER).

Ports:
- Clk  in  1  clock.
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk.
- Run  in  1  level request to multiply; already synchronised and debounced upstream.
- ClearA_LoadB  in  1  level request to load B from switches and clear A/X.
- M  in  1  B register bit 0 (Data_Out[0] of the B shift register).
- Ld_B  out  1  load B register from switches.
- Clr_A  out  1  clear A register and X flip-flop.
- Add  out  1  load A with the adder result and X with the result sign.
- Sub  out  1  adder in subtract mode; meaningful only with Add.
- Shift_En  out  1  shift A, B and X right together (X→A[7], A[0]→B[7]).
- Busy  out  1  operation in progress.
- Done  out  1  product valid in X:A:B; held until Run is released.

## Operation
- States: IDLE, START, ADD, SHIFT, HOLD; 3-bit iteration counter cnt.
- IDLE
  - Run=1: go to START.
  - ClearA_LoadB=1 and Run=0: Ld_B=1 and Clr_A=1 for that cycle; stay in IDLE.
  - Run and ClearA_LoadB both 1: Run wins; Ld_B and Clr_A stay 0.
- START: Clr_A=1; cnt←0; go to ADD.
- ADD: Add=M; Sub=M & (cnt==ITER-1); go to SHIFT.
- SHIFT: Shift_En=1; if cnt==ITER-1, go to HOLD; otherwise cnt←cnt+1 and go to ADD.
- HOLD: Done=1; if Run=0, go to IDLE.
  - Exactly one multiply per Run assertion; no auto-restart while Run is held.
- Busy=1 in START, ADD and SHIFT.
- ClearA_LoadB is ignored outside IDLE.
- Outputs are combinational from state, cnt, M and the IDLE inputs. They never assert two of Add/Shift_En/Clr_A/Ld_B in one cycle, except Ld_B+Clr_A in IDLE.
- Reset: state←IDLE, cnt←0. While Reset=1 every output is forced 0, independent of state. Reset mid-operation aborts; A/B/X contents are the datapath's concern.

## Timing
- Reset values: all outputs 0; state IDLE; cnt 0.
- Run sampled high at edge 0:
  - START during cycle 1.
  - ADD/SHIFT pairs occupy cycles 2–17: ADD on even cycles, SHIFT on odd cycles.
  - HOLD from cycle 18; Done=1 from cycle 18.
- Latency: 17 cycles from the Run edge to the first Done cycle.
- Shift_En pulses exactly 8 times and Clr_A exactly once per operation.
- Run release in HOLD at edge n: IDLE, Done=0 in cycle n+1.
- Run released before HOLD: no effect; the operation completes and Done lasts one cycle (HOLD sees Run=0).
- M is sampled combinationally in ADD. The datapath guarantees M is stable, since B changes only on Shift_En/Ld_B edges.

## Structure
- Package mult_pkg holds:
  - typedef enum logic [2:0] mult_state_t {IDLE, START, ADD, SHIFT, HOLD};
  - localparam MULT_ITER = 8; the ITER parameter defaults to it.
- Implementation: one always_ff for state/cnt, one always_comb for next-state and outputs, with defaults at the top.
- No sub-module; the counter is inline.
- The top-level multiplier instantiates mult_control beside two 8-bit shift registers, the X flop and the adder.

## Test plan
- Reset with Run=1 held → all outputs 0 during Reset. After release: START on the next cycle, then the normal sequence.
- ClearA_LoadB=1 for 3 cycles in IDLE, Run=0 → Ld_B=Clr_A=1 for exactly those 3 cycles; Add/Shift_En stay 0.
- Bench B model loaded with 8'hA5 (10100101), Run pulsed high and held:
  - Add asserts in iterations 0, 2, 5, 7; Sub only in iteration 7.
  - 8 Shift_En pulses; Done at cycle 18.
  - Full datapath gives X:A:B product for S=8'h07: 7 × (−91) = −637 = 16'hFD83.
- M=0 throughout (B=8'h00) → Add never asserts; 8 shifts; Done at cycle 18.
- Run held through HOLD for 10 cycles → Done stays 1, no second Clr_A; Run low → IDLE next cycle. Run high again → new START.
- Reset asserted in SHIFT of iteration 3 → outputs 0 that cycle; IDLE, cnt=0 next cycle; a new Run restarts at iteration 0.
